fifo_rd_packer: RTL and testbench
=================================

FIFO_RD_PACKER -- requirements
Module: fifo_rd_packer

Interface
REQ-001 Parameter DSIZE, default 8: width of one FIFO read word (byte lane).
REQ-002 Parameter LANES, default 4: lanes packed per output word; out_data width is DSIZE*LANES.
REQ-003 Parameter TIMEOUT, default 16: idle cycles before a partial word is flushed; legal range 2..255.
REQ-004 rclk  input  1  read-domain clock; all logic on rising edge; one clock only.
REQ-005 rrst_n  input  1  reset, synchronous, active-low.
REQ-006 rempty  input  1  FIFO empty flag, rclk domain.
REQ-007 read_data  input  DSIZE  FIFO read word, valid the cycle after an accepted pop.
REQ-008 rq  output  1  pop request; a pop is accepted on each rclk edge with rq=1 and rempty=0.
REQ-009 flush  input  1  one-cycle request to emit any partial word immediately.
REQ-010 out_data  output  DSIZE*LANES  packed word; first popped byte in bits [DSIZE-1:0].
REQ-011 out_bytes  output  3  valid lane count of out_data, 1..LANES.
REQ-012 out_valid  output  1  out_data/out_bytes valid.
REQ-013 out_ready  input  1  downstream accept; transfer when out_valid and out_ready both 1.

Function
REQ-014 rq shall be combinational: rq = !rempty && (acc_cnt + inflight < LANES) && state != FULL.
REQ-015 inflight shall be a register set to (rq && !rempty) each cycle, i.e. read latency exactly 1 cycle; back-to-back pops allowed.
REQ-016 When inflight=1, read_data shall be written into accumulator lane acc_cnt, and acc_cnt incremented by 1.
REQ-017 FSM states: EMPTY (acc_cnt=0), FILL (0<acc_cnt<LANES), FULL (acc_cnt=LANES, or partial word marked for flush).
REQ-018 FULL -> handoff: when output register free (out_valid=0, or out_ready=1 same cycle), accumulator shall move to out_data, out_bytes=acc_cnt, out_valid=1, acc_cnt=0, state EMPTY.
REQ-019 Capture in a handoff cycle shall land in lane 0 of the new accumulator (acc_cnt=1, state FILL); no byte lost or duplicated.
REQ-020 Output register shall hold out_data/out_bytes stable while out_valid=1 and out_ready=0.
REQ-021 out_valid shall clear the cycle after accept unless a new handoff occurs that cycle.
REQ-022 Idle counter: increments each cycle in FILL with rempty=1 and inflight=0; clears otherwise; at TIMEOUT-1 shall mark partial word for flush (state FULL).
REQ-023 flush=1 in FILL shall mark partial word for flush after any inflight capture in the same cycle completes; flush in EMPTY shall be ignored.
REQ-024 No pops shall be issued while a partial word is marked for flush; unused lanes of out_data shall be zero.
REQ-025 Unaccepted rq (rempty=1) shall have no effect; rq may stay asserted.

Reset
REQ-026 rrst_n=0 sampled at rising rclk shall set: out_valid=0, out_data=0, out_bytes=0, acc_cnt=0, inflight=0, idle counter=0, state EMPTY.
REQ-027 rq shall be 0 while rrst_n=0.
REQ-028 Reset mid-operation shall discard accumulator, output register and any inflight byte without a partial emit.

Verification
REQ-029 FIFO holds 0x11,0x12,0x13,0x14, out_ready=1 -> 4 consecutive rq pops; out_data=0x14131211, out_bytes=4, out_valid one cycle, 6 cycles after first pop.
REQ-030 FIFO holds 8 bytes 0x21..0x28, out_ready=0 for 20 cycles then 1 -> first word 0x24232221 held stable, second 0x28272625 accumulates, rq low when both full; both words delivered in order.
REQ-031 FIFO holds 0x31,0x32 then empty -> after TIMEOUT=16 idle cycles out_data=0x00003231, out_bytes=2.
REQ-032 FIFO holds 0x41 only, flush pulse 3 cycles later -> out_data=0x00000041, out_bytes=1 next cycle; flush with accumulator empty -> no output.
REQ-033 rrst_n low mid-word after 0x51,0x52 popped -> out_valid stays 0, next bytes 0x53..0x56 produce 0x56555453.
REQ-034 FIFO rempty toggling each cycle with 0x61..0x68 -> two words 0x64636261, 0x68676665, no byte loss, rq never accepted while rempty=1.

Source files
------------

// File: rtl/fifo_rd_packer.sv
// Packs single-lane FIFO reads into multi-lane words. A partial word is
// emitted on an explicit flush or after an idle timeout.
module fifo_rd_packer #(
  parameter int unsigned DSIZE   = 8,
  parameter int unsigned LANES   = 4,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                   rclk,
  input  logic                   rrst_n,
  input  logic                   rempty,
  input  logic [DSIZE-1:0]       read_data,
  output logic                   rq,
  input  logic                   flush,
  output logic [DSIZE*LANES-1:0] out_data,
  output logic [2:0]             out_bytes,
  output logic                   out_valid,
  input  logic                   out_ready
);

  localparam int unsigned CW = $clog2(LANES + 1);
  localparam logic [CW-1:0] LanesC = CW'(LANES);
  localparam logic [CW:0] LanesW = (CW + 1)'(LANES);
  localparam logic [7:0] TimeoutM1 = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {StEmpty, StFill, StFull} state_e;

  state_e                 state;
  logic [DSIZE*LANES-1:0] acc;
  logic [CW-1:0]          acc_cnt;
  logic                   inflight;
  logic [7:0]             idle_cnt;

  logic [DSIZE*LANES-1:0] acc_cap;
  logic [CW-1:0]          cnt_cap;
  logic                   handoff;
  logic                   idle_hit;
  logic                   timeout;

  // Lanes still free must also cover a byte already in flight.
  assign rq = rrst_n && !rempty && (state != StFull) &&
              (({1'b0, acc_cnt} + {{CW{1'b0}}, inflight}) < LanesW);

  assign handoff  = (state == StFull) && (!out_valid || out_ready);
  assign idle_hit = (state == StFill) && rempty && !inflight;
  assign timeout  = idle_hit && (idle_cnt == TimeoutM1);

  // Accumulator contents after this cycle's capture, if any.
  always_comb begin
    acc_cap = acc;
    cnt_cap = acc_cnt;
    if (inflight) begin
      for (int i = 0; i < int'(LANES); i++) begin
        if (acc_cnt == CW'(i)) acc_cap[i*DSIZE +: DSIZE] = read_data;
      end
      cnt_cap = acc_cnt + 1'b1;
    end
  end

  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      state     <= StEmpty;
      acc       <= '0;
      acc_cnt   <= '0;
      inflight  <= 1'b0;
      idle_cnt  <= '0;
      out_data  <= '0;
      out_bytes <= '0;
      out_valid <= 1'b0;
    end else begin
      inflight <= rq;
      if (out_valid && out_ready) out_valid <= 1'b0;

      if (handoff) begin
        out_data  <= acc;
        out_bytes <= 3'(acc_cnt);
        out_valid <= 1'b1;
        acc       <= '0;
        acc_cnt   <= '0;
        idle_cnt  <= '0;
        state     <= StEmpty;
        // A byte arriving during handoff starts the next word.
        if (inflight) begin
          acc[DSIZE-1:0] <= read_data;
          acc_cnt        <= CW'(1);
          state          <= (LanesC == CW'(1)) ? StFull : StFill;
        end
      end else begin
        acc     <= acc_cap;
        acc_cnt <= cnt_cap;
        if (idle_hit && !timeout) idle_cnt <= idle_cnt + 1'b1;
        else                      idle_cnt <= '0;

        if (state == StFull)                           state <= StFull;
        else if (cnt_cap == LanesC)                    state <= StFull;
        else if ((state == StFill) && (flush || timeout)) state <= StFull;
        else if (cnt_cap != '0)                        state <= StFill;
        else                                           state <= StEmpty;
      end
    end
  end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Bench for fifo_rd_packer: FIFO/scoreboard model, directed scenarios with
// literal expectations, then a randomized run with a final drain check.
module tb_fifo_rd_packer;

  localparam int DSIZE   = 8;
  localparam int LANES   = 4;
  localparam int TIMEOUT = 16;

  logic        rclk = 1'b0;
  logic        rrst_n = 1'b0;
  logic        rempty = 1'b1;
  logic [7:0]  read_data = '0;
  logic        rq;
  logic        flush = 1'b0;
  logic [31:0] out_data;
  logic [2:0]  out_bytes;
  logic        out_valid;
  logic        out_ready = 1'b0;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  byte unsigned fifo_q[$];
  byte unsigned popped_q[$];
  logic [31:0]  log_data[$];
  int           log_bytes[$];
  int           log_cyc[$];

  bit hide = 1'b0;
  int first_pop_cyc = -1;
  int last_pop_cyc = -1;

  fifo_rd_packer #(.DSIZE(DSIZE), .LANES(LANES), .TIMEOUT(TIMEOUT)) dut (
    .rclk      (rclk),
    .rrst_n    (rrst_n),
    .rempty    (rempty),
    .read_data (read_data),
    .rq        (rq),
    .flush     (flush),
    .out_data  (out_data),
    .out_bytes (out_bytes),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 rclk = ~rclk;
  always @(posedge rclk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, got, exp);
    end
  endtask

  // One clock of FIFO behaviour: accept a pop on the edge, return the byte a cycle later.
  task automatic tick();
    bit pop;
    rempty = (fifo_q.size() == 0) || hide;
    #1;
    pop = rq && !rempty;
    if (pop) begin
      if (first_pop_cyc < 0) first_pop_cyc = cyc;
      last_pop_cyc = cyc;
    end
    @(posedge rclk);
    #1;
    if (pop) begin
      read_data = fifo_q.pop_front();
      popped_q.push_back(read_data);
    end else begin
      read_data = 8'($urandom);
    end
    flush = 1'b0;
    rempty = (fifo_q.size() == 0) || hide;
    @(negedge rclk);
  endtask

  task automatic do_reset();
    rrst_n = 1'b0;
    repeat (2) tick();
    popped_q.delete();
    rrst_n = 1'b1;
  endtask

  task automatic run_until(input string name, input int n, input int budget);
    int k;
    k = 0;
    while (log_data.size() < n && k < budget) begin
      tick();
      k++;
    end
    chk(name, 64'(log_data.size()), 64'(n));
  endtask

  task automatic push_seq(input byte unsigned first, input int count);
    for (int i = 0; i < count; i++) fifo_q.push_back(8'(first + i));
  endtask

  // Compare process: reset state, rq legality, hold stability and every transfer.
  logic        rst_prev = 1'b1;
  logic        hold_prev = 1'b0;
  logic [31:0] hold_data;
  logic [2:0]  hold_bytes;
  logic [31:0] exp_w;
  int          nb;

  always @(negedge rclk) begin
    #2;
    if (rst_prev) begin
      chk("reset_valid", 64'(out_valid), 64'(0));
      chk("reset_data", 64'(out_data), 64'(0));
      chk("reset_bytes", 64'(out_bytes), 64'(0));
    end
    if (!rrst_n) begin
      chk("reset_rq", 64'(rq), 64'(0));
      hold_prev = 1'b0;
    end else begin
      if (rempty) chk("rq_while_empty", 64'(rq), 64'(0));
      if (hold_prev) begin
        chk("hold_valid", 64'(out_valid), 64'(1));
        chk("hold_data", 64'(out_data), 64'(hold_data));
        chk("hold_bytes", 64'(out_bytes), 64'(hold_bytes));
      end
      if (out_valid && out_ready) begin
        nb = int'(out_bytes);
        exp_w = '0;
        chk("bytes_range", 64'(nb >= 1 && nb <= LANES), 64'(1));
        for (int i = 0; i < LANES; i++) begin
          if (i < nb) begin
            if (popped_q.size() > 0) exp_w[i*8 +: 8] = popped_q.pop_front();
            else chk("byte_underflow", 64'(popped_q.size()), 64'(1));
          end
        end
        chk("xfer_data", 64'(out_data), 64'(exp_w));
        log_data.push_back(out_data);
        log_bytes.push_back(nb);
        log_cyc.push_back(cyc);
      end
      hold_prev = out_valid && !out_ready;
      hold_data = out_data;
      hold_bytes = out_bytes;
    end
    rst_prev = !rrst_n;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int b;
    int fc;
    @(negedge rclk);
    do_reset();

    // Four bytes, ready downstream.
    out_ready = 1'b1;
    b = log_data.size();
    first_pop_cyc = -1;
    push_seq(8'h11, 4);
    run_until("029_done", b + 1, 40);
    chk("029_data", 64'(log_data[b]), 64'h14131211);
    chk("029_bytes", 64'(log_bytes[b]), 64'd4);
    chk("029_latency", 64'(log_cyc[b] - first_pop_cyc), 64'd6);
    chk("029_valid_once", 64'(out_valid), 64'd0);

    // Backpressure: both words full, rq held low with data still waiting.
    out_ready = 1'b0;
    b = log_data.size();
    push_seq(8'h21, 9);
    repeat (20) tick();
    chk("030_rq_low", 64'(rq), 64'd0);
    chk("030_held_valid", 64'(out_valid), 64'd1);
    chk("030_held_data", 64'(out_data), 64'h24232221);
    out_ready = 1'b1;
    run_until("030_done", b + 3, 80);
    chk("030_w0", 64'(log_data[b]), 64'h24232221);
    chk("030_w1", 64'(log_data[b+1]), 64'h28272625);
    chk("030_w2", 64'(log_data[b+2]), 64'h00000029);
    chk("030_w2_bytes", 64'(log_bytes[b+2]), 64'd1);

    // Idle timeout: one capture cycle, TIMEOUT idle cycles, one handoff cycle.
    repeat (3) tick();
    b = log_data.size();
    push_seq(8'h31, 2);
    run_until("031_done", b + 1, 60);
    chk("031_data", 64'(log_data[b]), 64'h00003231);
    chk("031_bytes", 64'(log_bytes[b]), 64'd2);
    chk("031_latency", 64'(log_cyc[b] - last_pop_cyc), 64'(TIMEOUT + 3));

    // Explicit flush of a single byte, then flush with nothing accumulated.
    b = log_data.size();
    push_seq(8'h41, 1);
    repeat (5) tick();
    flush = 1'b1;
    fc = cyc;
    tick();
    run_until("032_done", b + 1, 10);
    chk("032_data", 64'(log_data[b]), 64'h00000041);
    chk("032_bytes", 64'(log_bytes[b]), 64'd1);
    chk("032_latency", 64'(log_cyc[b] - fc), 64'd2);
    repeat (3) tick();
    b = log_data.size();
    flush = 1'b1;
    tick();
    repeat (30) tick();
    chk("032_empty_flush", 64'(log_data.size()), 64'(b));

    // Reset mid-word discards the partial bytes.
    b = log_data.size();
    push_seq(8'h51, 2);
    repeat (4) tick();
    do_reset();
    chk("033_valid_after_reset", 64'(out_valid), 64'd0);
    push_seq(8'h53, 4);
    run_until("033_done", b + 1, 40);
    chk("033_data", 64'(log_data[b]), 64'h56555453);
    chk("033_bytes", 64'(log_bytes[b]), 64'd4);

    // rempty toggling every cycle.
    b = log_data.size();
    push_seq(8'h61, 8);
    for (int k = 0; k < 80 && log_data.size() < b + 2; k++) begin
      hide = k[0];
      tick();
    end
    hide = 1'b0;
    chk("034_count", 64'(log_data.size()), 64'(b + 2));
    chk("034_w0", 64'(log_data[b]), 64'h64636261);
    chk("034_w1", 64'(log_data[b+1]), 64'h68676665);

    // Randomized traffic, backpressure, empty gaps and flushes.
    for (int k = 0; k < 3000; k++) begin
      if (fifo_q.size() < 16 && $urandom_range(2) == 0) fifo_q.push_back(8'($urandom));
      hide = ($urandom_range(3) == 0);
      out_ready = ($urandom_range(2) != 0);
      flush = ($urandom_range(39) == 0);
      tick();
    end
    hide = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 300 && (fifo_q.size() > 0 || popped_q.size() > 0); k++) tick();
    repeat (4) tick();
    chk("drain_fifo", 64'(fifo_q.size()), 64'd0);
    chk("drain_popped", 64'(popped_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
